// File: rtl/store_rmw_packer_if.sv
// Store-side bus bundle of store_rmw_packer: MEM-stage request/response plus
// the data-RAM port. The packer uses the slave view, its environment the master view.
interface store_rmw_packer_if #(
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_wdata;
  logic [1:0]        st_size;
  logic              st_done;
  logic              st_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;

  modport slave (
    input  st_valid, st_addr, st_wdata, st_size, mem_rdata,
    output st_ready, st_done, st_err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );

  modport master (
    output st_valid, st_addr, st_wdata, st_size, mem_rdata,
    input  st_ready, st_done, st_err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/store_rmw_packer.sv
// MEM-stage store narrowing unit: places byte/half/word stores into a memory
// without byte enables via read-modify-write. Optional macro: STORE_ALIGN_CHECK_EN.
module store_rmw_packer #(
  parameter int ADDR_W         = 32,
  parameter int WORD_ONLY_FAST = 1
) (
  input  logic                clk,
  input  logic                rst,
  store_rmw_packer_if.slave   bus,
  output logic [2:0]          dbg_state_o
);
  // Handshake: a request is taken on a rising edge where st_valid & st_ready;
  // st_ready is high only in IDLE, so st_valid during a store is ignored and
  // the requester holds its request. st_done pulses once per accepted request,
  // with st_err qualifying it.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_MRG  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              st_ready_q, st_ready_d;
  logic              st_done_q, st_done_d;
  logic              st_err_q, st_err_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       merged;
  logic              accept, reject, fast;

  assign accept = bus.st_valid & st_ready_q;
  assign fast   = (WORD_ONLY_FAST != 0) && (bus.st_size == 2'b00);

`ifdef STORE_ALIGN_CHECK_EN
  assign reject = (bus.st_size == 2'b11)
                | ((bus.st_size == 2'b01) & bus.st_addr[0])
                | ((bus.st_size == 2'b00) & (bus.st_addr[1:0] != 2'b00));
`else
  assign reject = (bus.st_size == 2'b11);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wdata_q     <= '0;
      size_q      <= '0;
      off_q       <= '0;
      st_ready_q  <= 1'b1;
      st_done_q   <= 1'b0;
      st_err_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      st_ready_q  <= st_ready_d;
      st_done_q   <= st_done_d;
      st_err_q    <= st_err_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (accept) begin
        wdata_q <= bus.st_wdata;
        size_q  <= bus.st_size;
        off_q   <= bus.st_addr[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (reject)    state_d = S_RESP;
          else if (fast) state_d = S_WR;
          else           state_d = S_RD;
        end
      end
      S_RD:    state_d = S_MRG;
      S_MRG:   state_d = S_WR;
      S_WR:    state_d = S_IDLE;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Little-endian lane replacement on the word read back during RD.
  always_comb begin
    merged = bus.mem_rdata;
    case (size_q)
      2'b10:   merged[{off_q, 3'b000} +: 8]         = wdata_q[7:0];
      2'b01:   merged[{off_q[1], 4'b0000} +: 16]    = wdata_q[15:0];
      default: merged                               = wdata_q;
    endcase
  end

  // Outputs are decoded from the next state and registered so each strobe
  // lines up with the state it belongs to.
  always_comb begin
    st_ready_d  = (state_d == S_IDLE);
    st_done_d   = (state_d == S_WR) || (state_d == S_RESP);
    st_err_d    = (state_d == S_RESP);
    rd_en_d     = (state_d == S_RD);
    wr_en_d     = (state_d == S_WR);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (accept && !reject) begin
      mem_addr_d = {bus.st_addr[ADDR_W-1:2], 2'b00};
      if (fast) mem_wdata_d = bus.st_wdata;
    end
    if (state_q == S_MRG) mem_wdata_d = merged;
  end

  assign bus.st_ready  = st_ready_q;
  assign bus.st_done   = st_done_q;
  assign bus.st_err    = st_err_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_store_rmw_packer.sv
// Bench for store_rmw_packer: table of directed stores, reset/back-to-back
// sequences and random stores checked against a byte-lane memory model.
module tb_store_rmw_packer;
  localparam int FAST = 1;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  store_rmw_packer_if #(.ADDR_W(32)) bus ();

  store_rmw_packer #(.ADDR_W(32), .WORD_ONLY_FAST(FAST)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data RAM: one-cycle read latency, plus a preload port for the bench
  logic [31:0] ram [64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    else if (bus.mem_wr_en) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr[7:2]];
  end

  // strobe monitor
  int wr_total = 0;
  int overlap  = 0;
  always @(negedge clk) begin
    if (bus.mem_wr_en) wr_total++;
    if (bus.mem_rd_en && bus.mem_wr_en) overlap++;
  end

  // reference memory image
  logic [31:0] ref_mem [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = data;
  endtask

  function automatic logic ref_err(input logic [31:0] addr, input logic [1:0] size);
    logic e;
    e = (size == 2'b11);
`ifdef STORE_ALIGN_CHECK_EN
    if (size == 2'b01 && addr[0]) e = 1'b1;
    if (size == 2'b00 && addr[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  // byte-by-byte view: which memory bytes a store owns and what lands there
  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wdata,
                                            input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      case (size)
        2'b00: r[8*b +: 8] = wdata[8*b +: 8];
        2'b01: if ((b / 2) == int'(addr[1])) r[8*b +: 8] = wdata[8*(b % 2) +: 8];
        2'b10: if (b == int'(addr[1:0])) r[8*b +: 8] = wdata[7:0];
        default: ;
      endcase
    end
    return r;
  endfunction

  // issue one store, observe it to completion and score it against the model
  task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, output int lat, output logic err_seen);
    logic [5:0]  idx;
    logic        e;
    logic [31:0] expw;
    int          exp_lat, n, reads, writes, wr_cyc;
    logic [31:0] wr_addr, wr_data;
    logic        done;
    idx     = addr[7:2];
    e       = ref_err(addr, size);
    expw    = ref_merge(ref_mem[idx], wdata, size, addr);
    exp_lat = (e || (size == 2'b00 && FAST != 0)) ? 2 : 4;
    @(negedge clk);
    check("ready_idle", {31'd0, bus.st_ready}, 32'd1);
    bus.st_valid = 1'b1; bus.st_addr = addr; bus.st_wdata = wdata; bus.st_size = size;
    @(posedge clk);
    n = 1; done = 1'b0; reads = 0; writes = 0; wr_cyc = 0;
    wr_addr = '0; wr_data = '0; lat = 0; err_seen = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      // junk request while busy must be ignored
      bus.st_valid = 1'($urandom_range(0, 1));
      bus.st_addr = {24'd0, 8'($urandom)}; bus.st_wdata = $urandom; bus.st_size = 2'($urandom);
      if (bus.mem_rd_en) begin
        reads++;
        check("rd_addr", bus.mem_addr, {addr[31:2], 2'b00});
      end
      if (bus.mem_wr_en) begin
        writes++; wr_cyc = n; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata;
      end
      if (bus.st_done) begin
        done = 1'b1; lat = n; err_seen = bus.st_err;
      end
    end
    bus.st_valid = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", lat, exp_lat);
    check("st_err", {31'd0, err_seen}, {31'd0, e});
    check("reads", reads, (!e && exp_lat == 4) ? 1 : 0);
    check("writes", writes, e ? 0 : 1);
    if (!e) begin
      check("wr_addr", wr_addr, {addr[31:2], 2'b00});
      check("wr_data", wr_data, expw);
      check("wr_with_done", wr_cyc, lat);
      ref_mem[idx] = expw;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] init;
    logic [31:0] exp_word;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          lat;
    logic        err;
    int          wr_before;
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_wdata = '0; bus.st_size = '0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;

    vecs[0] = '{32'h10, 32'hDEADBEEF, 2'b00, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[1] = '{32'h23, 32'h000000AB, 2'b10, 32'h11223344, 32'hAB223344, 1'b0, 4};
    vecs[2] = '{32'h42, 32'hFFFF5A5A, 2'b01, 32'h11223344, 32'h5A5A3344, 1'b0, 4};
    vecs[3] = '{32'h54, 32'h12345678, 2'b11, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 2};
`ifdef STORE_ALIGN_CHECK_EN
    vecs[4] = '{32'h41, 32'h1234BEEF, 2'b01, 32'h11223344, 32'h11223344, 1'b1, 2};
    vecs[8] = '{32'h83, 32'h01020304, 2'b00, 32'h99999999, 32'h99999999, 1'b1, 2};
`else
    vecs[4] = '{32'h41, 32'h1234BEEF, 2'b01, 32'h11223344, 32'h1122BEEF, 1'b0, 4};
    vecs[8] = '{32'h83, 32'h01020304, 2'b00, 32'h99999999, 32'h01020304, 1'b0, 2};
`endif
    vecs[5] = '{32'h60, 32'h00000077, 2'b10, 32'hAABBCCDD, 32'hAABBCC77, 1'b0, 4};
    vecs[6] = '{32'h6E, 32'h0000BEEF, 2'b01, 32'h00000000, 32'hBEEF0000, 1'b0, 4};
    vecs[7] = '{32'h71, 32'hFFFFFF12, 2'b10, 32'hAABBCCDD, 32'hAABB12DD, 1'b0, 4};

    // reset and idle values
    rst = 1'b1;
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
    check("rst_ready", {31'd0, bus.st_ready}, 32'd1);
    check("rst_done", {31'd0, bus.st_done}, 32'd0);
    check("rst_err", {31'd0, bus.st_err}, 32'd0);
    check("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    check("rst_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", {31'd0, bus.st_ready}, 32'd1);
    check("idle_strobes", {30'd0, bus.mem_rd_en, bus.mem_wr_en}, 32'd0);

    // directed table
    for (int i = 0; i < 9; i++) begin
      preload(vecs[i].addr[7:2], vecs[i].init);
      do_store(vecs[i].addr, vecs[i].wdata, vecs[i].size, lat, err);
      @(negedge clk);
      check("tbl_word", ram[vecs[i].addr[7:2]], vecs[i].exp_word);
      check("tbl_lat", lat, vecs[i].exp_lat);
      check("tbl_err", {31'd0, err}, {31'd0, vecs[i].exp_err});
    end

    // back-to-back byte stores to the same word
    preload(6'h08, 32'h11223344);
    do_store(32'h20, 32'h000000AB, 2'b10, lat, err);
    do_store(32'h21, 32'h000000CD, 2'b10, lat, err);
    @(negedge clk);
    check("b2b_word", ram[8], 32'h1122CDAB);

    // reset in the middle of an RMW
    preload(6'h09, 32'h55667788);
    wr_before = wr_total;
    @(negedge clk);
    bus.st_valid = 1'b1; bus.st_addr = 32'h25; bus.st_wdata = 32'h99; bus.st_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    bus.st_valid = 1'b0;
    check("abort_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'd0, bus.st_ready}, 32'd1);
    check("abort_done", {31'd0, bus.st_done}, 32'd0);
    check("abort_strobes", {30'd0, bus.mem_rd_en, bus.mem_wr_en}, 32'd0);
    check("abort_mem_addr", bus.mem_addr, 32'd0);
    check("abort_mem_wdata", bus.mem_wdata, 32'd0);
    repeat (6) @(negedge clk);
    check("abort_no_write", wr_total, wr_before);
    check("abort_word", ram[9], 32'h55667788);

    // random stores against the model
    for (int i = 0; i < 60; i++) begin
      do_store({24'd0, 8'($urandom_range(0, 255))}, $urandom,
               2'($urandom_range(0, 3)), lat, err);
    end
    @(negedge clk);
    for (int i = 0; i < 64; i++) check("final_mem", ram[i], ref_mem[i]);
    check("rd_wr_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
